// File: rtl/fifo_sync_fwft_adapter.sv
// First-word-fall-through read adapter for a 1-cycle-latency synchronous FIFO.
// Optional delivered-word counter enabled by FIFO_SYNC_FWFT_ADAPTER_DCNT_EN.
module fifo_sync_fwft_adapter #(
    parameter int g_W     = 72,
    parameter int g_CNT_W = 32
) (
    input  logic               i_clk,
    input  logic               i_srst_n,
    output logic               o_fifo_rena,
    input  logic [g_W-1:0]     i_fifo_rdat,
    input  logic               i_fifo_empt,
    input  logic               i_flush,
    output logic               o_valid,
    output logic [g_W-1:0]     o_data,
    input  logic               i_ready,
    output logic [1:0]         o_occ,
    output logic [g_CNT_W-1:0] o_dcnt
);

    logic [g_W-1:0] head;
    logic [g_W-1:0] skid;
    logic [g_W-1:0] head_nxt;
    logic [g_W-1:0] skid_nxt;
    logic [1:0]     occ;
    logic [1:0]     occ_nxt;
    logic [1:0]     remain;
    logic [2:0]     demand;
    logic           valid;
    logic           inflight;
    logic           pop;
    logic           rena;

    assign pop = valid & i_ready;

    // Words we will still be holding next cycle, counting the one on the read port.
    assign demand = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign rena   = i_srst_n & ~i_flush & ~i_fifo_empt & (demand < 3'd2);

    always_comb begin
        // NOTE: every target gets a default first so no latch is inferred.
        head_nxt = head;
        skid_nxt = skid;
        remain   = occ - {1'b0, pop};
        occ_nxt  = remain + {1'b0, inflight};

        if (pop && occ == 2'd2) begin
            head_nxt = skid;
        end

        if (inflight) begin
            if (remain == 2'd0) begin
                head_nxt = i_fifo_rdat;
            end else begin
                skid_nxt = i_fifo_rdat;
            end
        end

        // Flush discards buffered words and the returning read, leaving o_data untouched.
        if (i_flush) begin
            head_nxt = head;
            skid_nxt = skid;
            occ_nxt  = 2'd0;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            occ      <= 2'd0;
            valid    <= 1'b0;
            inflight <= 1'b0;
            head     <= '0;
        end else begin
            occ      <= occ_nxt;
            valid    <= (occ_nxt != 2'd0);
            inflight <= rena;
            head     <= head_nxt;
        end
    end

    // NOTE: skid is data-only storage; no reset, since occ qualifies its contents.
    always_ff @(posedge i_clk) begin
        skid <= skid_nxt;
    end

`ifdef FIFO_SYNC_FWFT_ADAPTER_DCNT_EN
    logic [g_CNT_W-1:0] dcnt;

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            dcnt <= '0;
        end else if (pop && dcnt != '1) begin
            dcnt <= dcnt + g_CNT_W'(1);
        end
    end

    assign o_dcnt = dcnt;
`else
    assign o_dcnt = '0;
`endif

    assign o_fifo_rena = rena;
    assign o_valid     = valid;
    assign o_data      = head;
    assign o_occ       = occ;

endmodule

// File: tb/tb_fifo_sync_fwft_adapter.sv
// Scoreboard bench for fifo_sync_fwft_adapter with a behavioural upstream FIFO.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_fifo_sync_fwft_adapter;

    localparam int W       = 72;
    localparam int CW      = 32;
    localparam int NRAND   = 1000;
    localparam int FDEPTH  = 16;

    logic          clk     = 1'b0;
    logic          srst_n  = 1'b0;
    logic          flush   = 1'b0;
    logic          ready   = 1'b0;
    logic          fifo_empt = 1'b1;
    logic [W-1:0]  fifo_rdat = '0;
    logic          rena;
    logic          valid;
    logic [W-1:0]  data;
    logic [1:0]    occ;
    logic [CW-1:0] dcnt;

    logic          wen  = 1'b0;
    logic [W-1:0]  wdat = '0;

    logic [W-1:0]  fifo_q[$];
    logic [W-1:0]  exp_q[$];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            drop;
    int unsigned   delivered = 0;
    bit            hold_prev = 1'b0;
    logic [W-1:0]  prev_data = '0;
    logic [CW-1:0] dcnt_exp;

    fifo_sync_fwft_adapter #(.g_W(W), .g_CNT_W(CW)) dut (
        .i_clk       (clk),
        .i_srst_n    (srst_n),
        .o_fifo_rena (rena),
        .i_fifo_rdat (fifo_rdat),
        .i_fifo_empt (fifo_empt),
        .i_flush     (flush),
        .o_valid     (valid),
        .o_data      (data),
        .i_ready     (ready),
        .o_occ       (occ),
        .o_dcnt      (dcnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Upstream FIFO: 1-cycle read latency, empty flag registered from its level.
    always @(posedge clk) begin
        cyc++;
        if (!srst_n) begin
            fifo_q.delete();
            fifo_rdat <= '0;
            fifo_empt <= 1'b1;
        end else begin
            if (rena) begin
                check("read_while_empty", W'(fifo_empt), W'(0));
                if (fifo_q.size() > 0) fifo_rdat <= fifo_q.pop_front();
            end
            if (wen) begin
                fifo_q.push_back(wdat);
                exp_q.push_back(wdat);
            end
            fifo_empt <= (fifo_q.size() == 0);
        end
    end

    // Monitor: compares every accepted word against the scoreboard.
    always @(negedge clk) begin
        if (!srst_n) begin
            exp_q.delete();
            delivered = 0;
            hold_prev = 1'b0;
        end else begin
`ifdef FIFO_SYNC_FWFT_ADAPTER_DCNT_EN
            dcnt_exp = CW'(delivered);
`else
            dcnt_exp = '0;
`endif
            check("dcnt", W'(dcnt), W'(dcnt_exp));
            if (hold_prev) begin
                check("hold_valid", W'(valid), W'(1));
                check("hold_data", data, prev_data);
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) check("spurious_word", W'(valid), W'(0));
                else check("data_order", data, exp_q.pop_front());
                delivered++;
            end
            // Every word already read out of the FIFO but not yet accepted is lost.
            if (flush) begin
                drop = exp_q.size() - fifo_q.size();
                repeat (drop) void'(exp_q.pop_front());
            end
            hold_prev = valid && !ready && !flush;
            prev_data = data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [W-1:0] d);
        wdat = d;
        wen  = 1'b1;
        step();
        wen  = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (valid) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) check("valid_timeout", W'(valid), W'(1));
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        ready = 1'b1;
        while ((exp_q.size() != 0 || valid) && n < max_cyc) begin
            step();
            n++;
        end
        check("drain_left", W'(exp_q.size()), W'(0));
    endtask

    initial begin
        int w_cyc;
        int seen;
        int run;
        int sent;
        int budget;

        // Reset values
        repeat (3) step();
        @(negedge clk);
        check("rst_valid", W'(valid), W'(0));
        check("rst_data", data, W'(0));
        check("rst_occ", W'(occ), W'(0));
        check("rst_dcnt", W'(dcnt), W'(0));
        check("rst_rena", W'(rena), W'(0));
        step();
        srst_n = 1'b1;

        // Fall-through latency
        ready = 1'b1;
        w_cyc = cyc;
        write_word(W'(8'hA5));
        wait_valid(20, seen);
        check("ft_latency", W'(seen - w_cyc), W'(3));
        check("ft_data", data, W'(8'hA5));
        @(negedge clk);
        check("ft_one_cycle", W'(valid), W'(0));
        check("ft_occ", W'(occ), W'(0));

        // Streaming 16 words from a preloaded FIFO
        step();
        ready = 1'b0;
        for (int i = 0; i < 16; i++) write_word(W'(i));
        repeat (4) step();
        ready = 1'b1;
        run = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid) run++;
            else if (run > 0) break;
        end
        check("stream_run", W'(run), W'(16));
        step();
        drain(50);

        // Back-pressure
        ready = 1'b0;
        for (int i = 0; i < 8; i++) write_word(W'(i));
        repeat (6) step();
        @(negedge clk);
        check("bp_occ", W'(occ), W'(2));
        check("bp_rena", W'(rena), W'(0));
        check("bp_data", data, W'(0));
        check("bp_fifo_level", W'(fifo_q.size()), W'(6));
        step();
        drain(100);

        // Random ready with random writes
        sent = 0;
        budget = 0;
        while (sent < NRAND && budget < 20000) begin
            ready = 1'($urandom % 2);
            if (fifo_q.size() < FDEPTH && ($urandom % 4) != 0) begin
                wdat = W'({$urandom(), $urandom(), $urandom()});
                wen  = 1'b1;
                sent++;
            end
            step();
            wen = 1'b0;
            budget++;
        end
        check("rand_sent", W'(sent), W'(NRAND));
        drain(200);

        // Flush with a read in flight
        ready = 1'b0;
        write_word(W'(72'h11_1111));
        @(negedge clk);
        check("fl_rena_issued", W'(rena), W'(1));
        step();
        flush = 1'b1;
        @(negedge clk);
        check("fl_no_read", W'(rena), W'(0));
        step();
        flush = 1'b0;
        @(negedge clk);
        check("fl_valid", W'(valid), W'(0));
        check("fl_occ", W'(occ), W'(0));
        repeat (3) step();
        @(negedge clk);
        check("fl_stays_empty", W'(occ), W'(0));
        step();
        write_word(W'(72'h22_2222));
        wait_valid(20, seen);
        check("fl_next_word", data, W'(72'h22_2222));
        step();
        drain(50);

        // Mid-stream reset with two words buffered
        ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(W'(8'h10 + i));
        repeat (4) step();
        @(negedge clk);
        check("mr_occ_before", W'(occ), W'(2));
        step();
        srst_n = 1'b0;
        @(negedge clk);
        check("mr_rena_gated", W'(rena), W'(0));
        step();
        srst_n = 1'b1;
        @(negedge clk);
        check("mr_valid", W'(valid), W'(0));
        check("mr_data", data, W'(0));
        check("mr_occ", W'(occ), W'(0));
        check("mr_dcnt", W'(dcnt), W'(0));
        step();
        ready = 1'b1;
        write_word(W'(8'h3C));
        wait_valid(20, seen);
        check("mr_first_word", data, W'(8'h3C));
        step();
        drain(50);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
